// File: rtl/coin_pkg.sv
// Shared coin constants for the vending machine front end and complex_fsm.
package coin_pkg;

  localparam int         CNT_W      = 20;
  localparam logic [7:0] HALF_UNITS = 8'd1;
  localparam logic [7:0] ONE_UNITS  = 8'd2;
  localparam logic [7:0] TOTAL_MAX  = 8'd255;

  // Saturating add of coin units onto a running total.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, TOTAL_MAX}) begin
      return TOTAL_MAX;
    end else begin
      return sum[7:0];
    end
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser, mismatch-window debouncer and press-edge pulse for one raw key.
module key_debounce
  import coin_pkg::*;
#(
  parameter logic [CNT_W-1:0] CNT_MAX = 20'd999_999,
  parameter logic             KEY_ACT = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_press
);

  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic             armed_q, armed_d;
  logic [1:0]       prime_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A key held through reset must be seen released (once s2 carries a real sample) before presses count.
  always_comb begin
    cnt_d    = {CNT_W{1'b0}};
    stable_d = stable_q;
    press_d  = 1'b0;
    armed_d  = armed_q | (prime_q[1] & (s2_q == !KEY_ACT));
    if (s2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = s2_q;
        if (s2_q == KEY_ACT) begin
          press_d = armed_q;
        end else begin
          press_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1_q     <= !KEY_ACT;
      s2_q     <= !KEY_ACT;
      stable_q <= !KEY_ACT;
      cnt_q    <= {CNT_W{1'b0}};
      press_q  <= 1'b0;
      armed_q  <= 1'b0;
      prime_q  <= 2'b00;
    end else begin
      s1_q     <= key_in;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
      armed_q  <= armed_d;
      prime_q  <= {prime_q[0], 1'b1};
    end
  end

  assign key_press = press_q;

endmodule

// File: rtl/coin_key_ctrl.sv
// Coin key front end: two debouncers, half-first pulse arbiter and saturating coin total.
module coin_key_ctrl
  import coin_pkg::*;
#(
  parameter logic [CNT_W-1:0] CNT_MAX = 20'd999_999,
  parameter logic             KEY_ACT = 1'b0
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key_half,
  input  logic       key_one,
  input  logic       clr_cnt,
  output logic       po_money_half,
  output logic       po_money_one,
  output logic [7:0] coin_total
);

  logic       press_half_s, press_one_s;
  logic       pend_half_s, pend_one_s;
  logic       pend_half_q, pend_half_d;
  logic       pend_one_q, pend_one_d;
  logic       po_half_q, po_half_d;
  logic       po_one_q, po_one_d;
  logic [7:0] total_q, total_d;

  key_debounce #(.CNT_MAX(CNT_MAX), .KEY_ACT(KEY_ACT)) u_deb_half (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .key_in   (key_half),
    .key_press(press_half_s)
  );

  key_debounce #(.CNT_MAX(CNT_MAX), .KEY_ACT(KEY_ACT)) u_deb_one (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .key_in   (key_one),
    .key_press(press_one_s)
  );

  // A fresh press is eligible the same cycle it arrives, so no extra latency is added.
  always_comb begin
    pend_half_s = pend_half_q | press_half_s;
    pend_one_s  = pend_one_q | press_one_s;
    po_half_d   = pend_half_s;
    po_one_d    = pend_one_s & ~pend_half_s;
    pend_half_d = pend_half_s & ~po_half_d;
    pend_one_d  = pend_one_s & ~po_one_d;
    if (clr_cnt) begin
      total_d = 8'd0;
    end else if (po_half_d) begin
      total_d = sat_add(total_q, HALF_UNITS);
    end else if (po_one_d) begin
      total_d = sat_add(total_q, ONE_UNITS);
    end else begin
      total_d = total_q;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pend_half_q <= 1'b0;
      pend_one_q  <= 1'b0;
      po_half_q   <= 1'b0;
      po_one_q    <= 1'b0;
      total_q     <= 8'd0;
    end else begin
      pend_half_q <= pend_half_d;
      pend_one_q  <= pend_one_d;
      po_half_q   <= po_half_d;
      po_one_q    <= po_one_d;
      total_q     <= total_d;
    end
  end

  assign po_money_half = po_half_q;
  assign po_money_one  = po_one_q;
  assign coin_total    = total_q;

endmodule

// File: tb/tb_coin_key_ctrl.sv
// Directed bench for coin_key_ctrl with a short debounce window (CNT_MAX=4).
module tb_coin_key_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       key_half, key_one, clr_cnt;
  logic       po_money_half, po_money_one;
  logic [7:0] coin_total;

  int n_checks = 0;
  int n_fail   = 0;
  int n_half   = 0;
  int n_one    = 0;
  int n_both   = 0;
  int h0, o0;

  coin_key_ctrl #(.CNT_MAX(20'd4), .KEY_ACT(1'b0)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .key_half     (key_half),
    .key_one      (key_one),
    .clr_cnt      (clr_cnt),
    .po_money_half(po_money_half),
    .po_money_one (po_money_one),
    .coin_total   (coin_total)
  );

  always #10 sys_clk = ~sys_clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge sys_clk) begin
    if (po_money_half) n_half++;
    if (po_money_one) n_one++;
    if (po_money_half && po_money_one) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic press_half();
    key_half = 1'b0;
    repeat (12) tick();
    key_half = 1'b1;
    repeat (10) tick();
  endtask

  task automatic press_one();
    key_one = 1'b0;
    repeat (12) tick();
    key_one = 1'b1;
    repeat (10) tick();
  endtask

  initial begin
    key_half = 1'b1;
    key_one  = 1'b1;
    clr_cnt  = 1'b0;
    sys_rst  = 1'b1;
    repeat (3) tick();
    check("rst_half", po_money_half, 0);
    check("rst_one", po_money_one, 0);
    check("rst_total", coin_total, 0);
    sys_rst = 1'b0;
    repeat (5) tick();

    // 1: clean half press; pulse registered at edge N+7
    h0 = n_half; o0 = n_one;
    key_half = 1'b0;
    tick();
    repeat (6) tick();
    check("t1_pre", po_money_half, 0);
    tick();
    check("t1_pulse", po_money_half, 1);
    check("t1_total", coin_total, 1);
    tick();
    check("t1_width", po_money_half, 0);
    repeat (12) tick();
    key_half = 1'b1;
    repeat (10) tick();
    check("t1_count", n_half - h0, 1);
    check("t1_no_one", n_one - o0, 0);

    // 2: bouncing one key, then held low
    o0 = n_one;
    for (int i = 0; i < 8; i++) begin
      key_one = ((i / 2) % 2 == 1) ? 1'b1 : 1'b0;
      tick();
    end
    key_one = 1'b0;
    tick();
    repeat (6) tick();
    check("t2_pre", po_money_one, 0);
    tick();
    check("t2_pulse", po_money_one, 1);
    check("t2_total", coin_total, 3);
    repeat (20) tick();
    key_one = 1'b1;
    repeat (10) tick();
    check("t2_count", n_one - o0, 1);

    // 3: simultaneous presses, half first
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("t3_clr", coin_total, 0);
    key_half = 1'b0;
    key_one  = 1'b0;
    tick();
    repeat (6) tick();
    tick();
    check("t3_half", po_money_half, 1);
    check("t3_one_wait", po_money_one, 0);
    tick();
    check("t3_half_done", po_money_half, 0);
    check("t3_one", po_money_one, 1);
    check("t3_total", coin_total, 3);
    repeat (12) tick();
    key_half = 1'b1;
    key_one  = 1'b1;
    repeat (10) tick();

    // 4: saturation and clear priority
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    for (int k = 0; k < 127; k++) press_one();
    check("t4_254", coin_total, 254);
    press_one();
    check("t4_sat_one", coin_total, 255);
    press_half();
    check("t4_sat_half", coin_total, 255);
    key_half = 1'b0;
    tick();
    repeat (6) tick();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("t4_clr_pulse", po_money_half, 1);
    check("t4_clr_total", coin_total, 0);
    repeat (12) tick();
    key_half = 1'b1;
    repeat (10) tick();

    // 5: reset mid-debounce drops the coin; held key needs release first
    press_one();
    check("t5_pre_total", coin_total, 2);
    h0 = n_half;
    key_half = 1'b0;
    tick();
    repeat (2) tick();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    check("t5_rst_total", coin_total, 0);
    repeat (30) tick();
    check("t5_no_pulse", n_half - h0, 0);
    check("t5_half_low", po_money_half, 0);
    check("t5_total_held", coin_total, 0);
    key_half = 1'b1;
    repeat (20) tick();
    key_half = 1'b0;
    tick();
    repeat (6) tick();
    check("t5_pre", po_money_half, 0);
    tick();
    check("t5_pulse", po_money_half, 1);
    check("t5_total", coin_total, 1);

    // 6: long hold, release produces nothing
    repeat (12) tick();
    key_half = 1'b1;
    repeat (10) tick();
    h0 = n_half;
    key_half = 1'b0;
    tick();
    repeat (6) tick();
    tick();
    check("t6_pulse", po_money_half, 1);
    repeat (1000) tick();
    key_half = 1'b1;
    repeat (20) tick();
    check("t6_count", n_half - h0, 1);
    check("t6_total", coin_total, 2);

    check("never_both", n_both, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
